async_read_pointer: RTL and testbench

Read-side pointer and status controller for the dual-clock FIFO. It is the counterpart of the write-side pointer block.
- Owns the binary and gray read pointers and the RAM read address.
- Brings the write-domain gray pointer into rd_clk through a 2-flop synchronizer.
- Produces registered empty, almost_empty, fill level and underflow status for the consumer.
- Its gray_read_ptr output goes to the write-domain full-flag logic.

---
 rtl/async_read_pointer_if.sv | 24 ++
 rtl/async_read_pointer.sv | 79 +++++++
 tb/tb_async_read_pointer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/async_read_pointer_if.sv
// Read-side FIFO pointer bundle: the consumer request and write-domain gray pointer in,
// and the RAM address and read-domain status out.
interface async_read_pointer_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  read_en;
    logic [ADDR_WIDTH:0]   wr_gray_ptr;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH:0]   gray_read_ptr;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_level;
    logic                  underflow;

    modport master (
        output read_en, wr_gray_ptr,
        input  read_addr, gray_read_ptr, empty, almost_empty, rd_level, underflow
    );

    modport slave (
        input  read_en, wr_gray_ptr,
        output read_addr, gray_read_ptr, empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/async_read_pointer.sv
// Read-side pointer/status controller of the dual-clock FIFO: owns the read pointers,
// synchronizes the write gray pointer into rd_clk and produces registered status flags.
module async_read_pointer #(
    parameter int DEPTH               = 16,
    parameter int ADDR_WIDTH          = 4,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                 rd_clk,
    input  logic                 reset,
    async_read_pointer_if.slave  rd_if
);
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(ALMOST_EMPTY_THRESH);

    generate
        if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("async_read_pointer: DEPTH must equal 2**ADDR_WIDTH");
        end
    endgenerate

    logic [PTR_W-1:0] rbin_reg;
    logic [PTR_W-1:0] rgray_reg;
    logic [PTR_W-1:0] wq1_reg;
    logic [PTR_W-1:0] wq2_reg;
    logic [PTR_W-1:0] level_reg;
    logic             empty_reg;
    logic             almost_empty_reg;
    logic             underflow_reg;

    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] level_next;
    logic [PTR_W-1:0] wbin_sync;
    logic             rd_fire;

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PTR_W; gi++) begin : g_gray2bin
            assign wbin_sync[gi] = ^wq2_reg[PTR_W-1:gi];
        end
    endgenerate

    always_comb begin
        rd_fire    = rd_if.read_en & ~empty_reg;
        rbin_next  = rbin_reg + PTR_W'(rd_fire);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        level_next = wbin_sync - rbin_next;
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rbin_reg         <= '0;
            rgray_reg        <= '0;
            wq1_reg          <= '0;
            wq2_reg          <= '0;
            level_reg        <= '0;
            empty_reg        <= 1'b1;
            almost_empty_reg <= 1'b1;
            underflow_reg    <= 1'b0;
        end else begin
            wq1_reg          <= rd_if.wr_gray_ptr;
            wq2_reg          <= wq1_reg;
            rbin_reg         <= rbin_next;
            rgray_reg        <= rgray_next;
            // Compare against the post-read pointer so the final read raises empty on its own edge.
            empty_reg        <= (rgray_next == wq2_reg);
            level_reg        <= level_next;
            almost_empty_reg <= (level_next <= AE_THRESH);
            underflow_reg    <= rd_if.read_en & empty_reg;
        end
    end

    assign rd_if.read_addr     = rbin_reg[ADDR_WIDTH-1:0];
    assign rd_if.gray_read_ptr = rgray_reg;
    assign rd_if.empty         = empty_reg;
    assign rd_if.almost_empty  = almost_empty_reg;
    assign rd_if.rd_level      = level_reg;
    assign rd_if.underflow     = underflow_reg;
endmodule

// File: tb/tb_async_read_pointer.sv
// Directed bench for async_read_pointer: vector table for reset/first-entry/underflow,
// then hand-written burst, wrap, simultaneous-update and async-reset sequences.
module tb_async_read_pointer;
    logic rd_clk = 1'b0;
    logic reset  = 1'b1;

    async_read_pointer_if #(.ADDR_WIDTH(4)) rd_if ();

    async_read_pointer #(
        .DEPTH(16),
        .ADDR_WIDTH(4),
        .ALMOST_EMPTY_THRESH(2)
    ) dut (
        .rd_clk (rd_clk),
        .reset  (reset),
        .rd_if  (rd_if)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic       re;
        logic [4:0] wg;
        logic [3:0] addr;
        logic [4:0] gray;
        logic       emp;
        logic       ae;
        logic [4:0] lvl;
        logic       uf;
    } vec_t;

    vec_t tbl[8];

    logic [4:0] wptr;
    logic [4:0] rptr;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] addr, input logic [4:0] gray,
                             input logic emp, input logic ae, input logic [4:0] lvl, input logic uf);
        check({tag, ".read_addr"},     int'(rd_if.read_addr),     int'(addr));
        check({tag, ".gray_read_ptr"}, int'(rd_if.gray_read_ptr), int'(gray));
        check({tag, ".empty"},         int'(rd_if.empty),         int'(emp));
        check({tag, ".almost_empty"},  int'(rd_if.almost_empty),  int'(ae));
        check({tag, ".rd_level"},      int'(rd_if.rd_level),      int'(lvl));
        check({tag, ".underflow"},     int'(rd_if.underflow),     int'(uf));
        $display("%s: addr=%0d gray=%b empty=%b ae=%b level=%0d uf=%b", tag, rd_if.read_addr,
                 rd_if.gray_read_ptr, rd_if.empty, rd_if.almost_empty, rd_if.rd_level, rd_if.underflow);
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    // Write ahead by n, let it cross the synchronizer, then drain it one read per edge.
    task automatic do_burst(input int n, input string tag);
        wptr = wptr + 5'(n);
        rd_if.wr_gray_ptr = to_gray(wptr);
        rd_if.read_en = 1'b0;
        step();
        step();
        check({tag, ".pre_sync_level"}, int'(rd_if.rd_level), 0);
        step();
        check_all({tag, ".filled"}, rptr[3:0], to_gray(rptr), 1'b0, (n <= 2), 5'(n), 1'b0);
        for (int k = 1; k <= n; k++) begin
            rd_if.read_en = 1'b1;
            step();
            rptr = rptr + 5'd1;
            check_all($sformatf("%s.rd%0d", tag, k), rptr[3:0], to_gray(rptr),
                      (k == n), ((n - k) <= 2), 5'(n - k), 1'b0);
        end
        rd_if.read_en = 1'b0;
    endtask

    initial begin
        rd_if.read_en     = 1'b0;
        rd_if.wr_gray_ptr = 5'b00000;

        //          re    wg        addr gray      emp   ae    lvl uf
        tbl[0] = '{1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[1] = '{1'b0, 5'b00001, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[2] = '{1'b0, 5'b00001, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[3] = '{1'b0, 5'b00001, 4'd0, 5'b00000, 1'b0, 1'b1, 5'd1, 1'b0};
        tbl[4] = '{1'b1, 5'b00001, 4'd1, 5'b00001, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[5] = '{1'b1, 5'b00001, 4'd1, 5'b00001, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[6] = '{1'b1, 5'b00001, 4'd1, 5'b00001, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[7] = '{1'b0, 5'b00001, 4'd1, 5'b00001, 1'b1, 1'b1, 5'd0, 1'b0};

        step();
        step();
        check_all("reset_held", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd_if.read_en     = tbl[i].re;
            rd_if.wr_gray_ptr = tbl[i].wg;
            step();
            check_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].gray, tbl[i].emp,
                      tbl[i].ae, tbl[i].lvl, tbl[i].uf);
        end

        // Mid-stream reset: write side is reset concurrently.
        #2 reset = 1'b1;
        rd_if.wr_gray_ptr = 5'b00000;
        #1;
        check_all("reset_mid", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        reset = 1'b0;
        wptr = 5'd0;
        rptr = 5'd0;

        do_burst(16, "full16");
        do_burst(10, "wrapA");
        do_burst(10, "wrapB");
        check("wrap_rptr_bin", int'(rptr), 4);
        do_burst(4, "wrapC");

        // Read and write-pointer advance on the same edge.
        wptr = wptr + 5'd2;
        rd_if.wr_gray_ptr = to_gray(wptr);
        step(); step(); step();
        check("simul.pre_level", int'(rd_if.rd_level), 2);
        rd_if.read_en = 1'b1;
        wptr = wptr + 5'd1;
        rd_if.wr_gray_ptr = to_gray(wptr);
        step();
        rptr = rptr + 5'd1;
        rd_if.read_en = 1'b0;
        check("simul.edgeA_level", int'(rd_if.rd_level), 1);
        step();
        check("simul.edgeB_level", int'(rd_if.rd_level), 1);
        step();
        check_all("simul.edgeC", rptr[3:0], to_gray(rptr), 1'b0, 1'b1, 5'd2, 1'b0);

        // Async reset with level 10 and a read pending.
        wptr = wptr + 5'd8;
        rd_if.wr_gray_ptr = to_gray(wptr);
        step(); step(); step();
        check("rst6.pre_level", int'(rd_if.rd_level), 10);
        rd_if.read_en = 1'b1;
        #2 reset = 1'b1;
        rd_if.wr_gray_ptr = 5'b00000;
        #1;
        check_all("rst6.async", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        rd_if.read_en = 1'b0;
        step();
        reset = 1'b0;
        step();
        check_all("rst6.rel1", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        check_all("rst6.rel2", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
